fm_addr_sequencer: RTL and testbench



---
 rtl/fm_addr_sequencer_if.sv | 35 +++
 rtl/fm_addr_sequencer.sv | 141 ++++++++++++++
 tb/tb_fm_addr_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/fm_addr_sequencer_if.sv
// Control/address bus between the layer controller (master) and the
// feature-map address sequencer (slave).
interface fm_addr_sequencer_if #(
    parameter int W_SIZE    = 12,
    parameter int W_CHANNEL = 12,
    parameter int IFM_AW    = 16,
    parameter int OFM_AW    = 16
) ();
    logic [W_SIZE-1:0]           q_width;
    logic [W_SIZE-1:0]           q_height;
    logic [W_CHANNEL-1:0]        q_channel;
    logic [W_CHANNEL-1:0]        q_channel_out;
    logic [W_SIZE+W_CHANNEL-1:0] q_row_stride;
    logic                        q_addr_seq_start;
    logic                        q_as_mode;
    logic [IFM_AW-1:0]           q_route_offset;
    logic [W_CHANNEL-1:0]        q_route_chn_offset;
    logic                        addr_seq_done;
    logic                        as_rd_vld;
    logic [IFM_AW-1:0]           as_rd_addr;
    logic                        as_wr_vld;
    logic [OFM_AW-1:0]           as_wr_addr;

    modport master (
        output q_width, q_height, q_channel, q_channel_out, q_row_stride,
               q_addr_seq_start, q_as_mode, q_route_offset, q_route_chn_offset,
        input  addr_seq_done, as_rd_vld, as_rd_addr, as_wr_vld, as_wr_addr
    );

    modport slave (
        input  q_width, q_height, q_channel, q_channel_out, q_row_stride,
               q_addr_seq_start, q_as_mode, q_route_offset, q_route_chn_offset,
        output addr_seq_done, as_rd_vld, as_rd_addr, as_wr_vld, as_wr_addr
    );
endinterface

// File: rtl/fm_addr_sequencer.sv
// Feature-map address sequencer: streams read/write addresses for 2x nearest
// upsample (mode 0) or route channel concatenation (mode 1), one per cycle.
module fm_addr_sequencer #(
    parameter int W_SIZE       = 12,
    parameter int W_CHANNEL    = 12,
    parameter int W_FRAME_SIZE = 2,
    parameter int Tin          = 16,
    parameter int Tout         = 16,
    parameter int IFM_AW       = 16,
    parameter int OFM_AW       = 16
) (
    input  logic               clk,
    input  logic               rstn,
    fm_addr_sequencer_if.slave bus
);
    localparam int W_CNT    = W_SIZE + 1;
    localparam int W_STRIDE = W_SIZE + W_CHANNEL;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t state, state_nxt;

    logic                 mode_q;
    logic [W_CNT-1:0]     xlim_q, ylim_q;
    logic [W_CHANNEL-1:0] c_q, wstep_q, chn_q;
    logic [W_STRIDE-1:0]  stride_q;

    logic [W_CHANNEL-1:0] cnt_c;
    logic [W_CNT-1:0]     cnt_x, cnt_y;
    logic [IFM_AW-1:0]    row_base, pix_base;
    logic [OFM_AW-1:0]    wr_pix, wr_addr_q;
    logic                 wr_vld_q;

    logic last_c, last_x, last_y, last_elem, dims_zero;
    logic [IFM_AW-1:0] rd_cur, start_base, next_row;
    logic [OFM_AW-1:0] wr_cur;

    assign last_c    = (cnt_c == c_q - W_CHANNEL'(1));
    assign last_x    = (cnt_x == xlim_q - W_CNT'(1));
    assign last_y    = (cnt_y == ylim_q - W_CNT'(1));
    assign last_elem = last_c && last_x && last_y;
    assign dims_zero = (bus.q_width == '0) || (bus.q_height == '0) || (bus.q_channel == '0);

    // Upsample reads the zero-based input map; route reads from a programmable base.
    assign start_base = bus.q_as_mode ? bus.q_route_offset : '0;
    assign rd_cur     = pix_base + IFM_AW'(cnt_c);
    assign wr_cur     = wr_pix + OFM_AW'(chn_q) + OFM_AW'(cnt_c);
    assign next_row   = row_base + IFM_AW'(stride_q);

    always_ff @(posedge clk) begin
        // NOTE: rstn is a synchronous, active-high reset despite its name.
        if (rstn) state <= IDLE;
        else      state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt         = state;
        bus.as_rd_vld     = 1'b0;
        bus.addr_seq_done = 1'b0;
        unique case (state)
            IDLE:  if (bus.q_addr_seq_start) state_nxt = dims_zero ? FLUSH : RUN;
            RUN: begin
                bus.as_rd_vld = 1'b1;
                if (last_elem) state_nxt = FLUSH;
            end
            FLUSH: state_nxt = DONE;
            DONE: begin
                bus.addr_seq_done = 1'b1;
                state_nxt         = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The counters double as the read-address holder, so the last address
    // stays on as_rd_addr while idle.
    always_ff @(posedge clk) begin
        if (rstn) begin
            mode_q    <= 1'b0;
            xlim_q    <= '0;
            ylim_q    <= '0;
            c_q       <= '0;
            wstep_q   <= '0;
            chn_q     <= '0;
            stride_q  <= '0;
            cnt_c     <= '0;
            cnt_x     <= '0;
            cnt_y     <= '0;
            row_base  <= '0;
            pix_base  <= '0;
            wr_pix    <= '0;
            wr_addr_q <= '0;
            wr_vld_q  <= 1'b0;
        end else begin
            wr_vld_q <= (state == RUN);
            if (state == RUN) wr_addr_q <= wr_cur;

            if (state == IDLE && bus.q_addr_seq_start) begin
                mode_q   <= bus.q_as_mode;
                xlim_q   <= bus.q_as_mode ? {1'b0, bus.q_width}  : {bus.q_width, 1'b0};
                ylim_q   <= bus.q_as_mode ? {1'b0, bus.q_height} : {bus.q_height, 1'b0};
                c_q      <= bus.q_channel;
                wstep_q  <= bus.q_as_mode ? bus.q_channel_out : bus.q_channel;
                chn_q    <= bus.q_as_mode ? bus.q_route_chn_offset : '0;
                stride_q <= bus.q_row_stride;
                cnt_c    <= '0;
                cnt_x    <= '0;
                cnt_y    <= '0;
                row_base <= start_base;
                pix_base <= start_base;
                wr_pix   <= '0;
            end else if (state == RUN && !last_elem) begin
                if (!last_c) begin
                    cnt_c <= cnt_c + W_CHANNEL'(1);
                end else begin
                    cnt_c  <= '0;
                    wr_pix <= wr_pix + OFM_AW'(wstep_q);
                    if (!last_x) begin
                        cnt_x <= cnt_x + W_CNT'(1);
                        // Upsample reuses each input pixel for two output columns.
                        if (mode_q || cnt_x[0]) pix_base <= pix_base + IFM_AW'(c_q);
                    end else begin
                        cnt_x <= '0;
                        cnt_y <= cnt_y + W_CNT'(1);
                        if (mode_q || cnt_y[0]) begin
                            row_base <= next_row;
                            pix_base <= next_row;
                        end else begin
                            pix_base <= row_base;
                        end
                    end
                end
            end
        end
    end

    assign bus.as_rd_addr = rd_cur;
    assign bus.as_wr_vld  = wr_vld_q;
    assign bus.as_wr_addr = wr_addr_q;
endmodule

// File: tb/tb_fm_addr_sequencer.sv
// Scoreboard bench for fm_addr_sequencer: stimulus pushes expected addresses,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_fm_addr_sequencer;
    localparam int W_SIZE    = 12;
    localparam int W_CHANNEL = 12;
    localparam int IFM_AW    = 16;
    localparam int OFM_AW    = 16;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    fm_addr_sequencer_if #(
        .W_SIZE(W_SIZE), .W_CHANNEL(W_CHANNEL), .IFM_AW(IFM_AW), .OFM_AW(OFM_AW)
    ) bus ();

    fm_addr_sequencer #(
        .W_SIZE(W_SIZE), .W_CHANNEL(W_CHANNEL), .W_FRAME_SIZE(2),
        .Tin(16), .Tout(16), .IFM_AW(IFM_AW), .OFM_AW(OFM_AW)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int rd_q[$];
    int wr_q[$];
    int done_exp = 0;
    logic prev_rd = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event with nothing expected", name);
    endtask

    // Monitor: compares every presented address against the scoreboard.
    always @(negedge clk) begin
        if (rstn) begin
            prev_rd = 1'b0;
        end else begin
            if (bus.as_rd_vld) begin
                if (rd_q.size() == 0) fail_now("rd_unexpected");
                else check("rd_addr", 32'(bus.as_rd_addr), rd_q.pop_front());
            end
            if (bus.as_wr_vld || prev_rd) check("wr_vld_lag", 32'(bus.as_wr_vld), 32'(prev_rd));
            if (bus.as_wr_vld) begin
                if (wr_q.size() == 0) fail_now("wr_unexpected");
                else check("wr_addr", 32'(bus.as_wr_addr), wr_q.pop_front());
            end
            if (bus.addr_seq_done) begin
                if (done_exp == 0) fail_now("done_unexpected");
                else done_exp--;
                check("done_wr_vld_low", 32'(bus.as_wr_vld), 0);
            end
            prev_rd = bus.as_rd_vld;
        end
    end

    task automatic start_job(input logic mode, input int w, input int h, input int c,
                             input int cout, input int stride, input int off, input int choff);
        bus.q_as_mode          = mode;
        bus.q_width            = W_SIZE'(w);
        bus.q_height           = W_SIZE'(h);
        bus.q_channel          = W_CHANNEL'(c);
        bus.q_channel_out      = W_CHANNEL'(cout);
        bus.q_row_stride       = (W_SIZE + W_CHANNEL)'(stride);
        bus.q_route_offset     = IFM_AW'(off);
        bus.q_route_chn_offset = W_CHANNEL'(choff);
        bus.q_addr_seq_start   = 1'b1;
        @(posedge clk);
        #1 bus.q_addr_seq_start = 1'b0;
    endtask

    // Waits for done after a start; done must land n_addr+2 cycles after start.
    // poke > 0 re-asserts start with different inputs on that cycle.
    task automatic wait_done(input string name, input int n_addr, input int poke);
        int cycles = 0;
        bit seen = 0;
        while (!seen && cycles < 200) begin
            @(negedge clk);
            cycles++;
            bus.q_addr_seq_start = 1'b0;
            if (bus.addr_seq_done) seen = 1;
            if (cycles == poke) begin
                bus.q_width          = W_SIZE'(7);
                bus.q_channel        = W_CHANNEL'(3);
                bus.q_as_mode        = ~bus.q_as_mode;
                bus.q_addr_seq_start = 1'b1;
            end
        end
        check({name, "_done_latency"}, seen ? cycles : -1, n_addr + 2);
        check({name, "_rd_left"}, rd_q.size(), 0);
        check({name, "_wr_left"}, wr_q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        int up22[$] = '{0,0,1,1,0,0,1,1,2,2,3,3,2,2,3,3};
        int up212[$] = '{0,1,0,1,2,3,2,3,0,1,0,1,2,3,2,3};

        rstn = 1'b1;
        bus.q_addr_seq_start = 1'b0;
        start_job(1'b0, 0, 0, 0, 0, 0, 0, 0);
        bus.q_addr_seq_start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rd_vld", 32'(bus.as_rd_vld), 0);
        check("rst_wr_vld", 32'(bus.as_wr_vld), 0);
        check("rst_done", 32'(bus.addr_seq_done), 0);
        check("rst_rd_addr", 32'(bus.as_rd_addr), 0);
        check("rst_wr_addr", 32'(bus.as_wr_addr), 0);
        @(posedge clk);
        #1 rstn = 1'b0;
        @(negedge clk);

        // Route W=4 H=4 C=2 Cout=4 chn_offset 2: reads 0..31, writes 2,3,6,7,...
        for (int i = 0; i < 32; i++) begin
            rd_q.push_back(i);
            wr_q.push_back((i / 2) * 4 + 2 + (i % 2));
        end
        done_exp++;
        start_job(1'b1, 4, 4, 2, 4, 8, 0, 2);
        wait_done("route4x4", 32, 0);

        // Upsample W=2 H=2 C=1
        rd_q = up22;
        for (int i = 0; i < 16; i++) wr_q.push_back(i);
        done_exp++;
        start_job(1'b0, 2, 2, 1, 0, 2, 0, 0);
        wait_done("up2x2", 16, 0);

        // Upsample W=2 H=1 C=2 row_stride 4
        rd_q = up212;
        for (int i = 0; i < 16; i++) wr_q.push_back(i);
        done_exp++;
        start_job(1'b0, 2, 1, 2, 0, 4, 0, 0);
        wait_done("up2x1c2", 16, 0);

        // Route with base 100 and channel offset 1
        rd_q = '{100, 101};
        wr_q = '{1, 3};
        done_exp++;
        start_job(1'b1, 2, 1, 1, 2, 2, 100, 1);
        wait_done("route_off", 2, 0);
        check("idle_rd_hold", 32'(bus.as_rd_addr), 101);
        check("idle_wr_hold", 32'(bus.as_wr_addr), 3);
        check("idle_rd_vld", 32'(bus.as_rd_vld), 0);

        // Zero width: no addresses, done two cycles after start
        done_exp++;
        start_job(1'b0, 0, 3, 2, 0, 0, 0, 0);
        wait_done("zero_w", 0, 0);

        // Start re-asserted mid-run with changed inputs must be ignored
        rd_q = up22;
        for (int i = 0; i < 16; i++) wr_q.push_back(i);
        done_exp++;
        start_job(1'b0, 2, 2, 1, 0, 2, 0, 0);
        wait_done("restart_ignored", 16, 5);
        repeat (3) @(negedge clk);
        check("restart_single_done", done_exp, 0);

        // Reset mid-run aborts; a fresh start replays the full sequence
        for (int i = 0; i < 32; i++) begin
            rd_q.push_back(i);
            wr_q.push_back((i / 2) * 4 + 2 + (i % 2));
        end
        done_exp++;
        start_job(1'b1, 4, 4, 2, 4, 8, 0, 2);
        repeat (6) @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_rd_vld", 32'(bus.as_rd_vld), 0);
        check("abort_wr_vld", 32'(bus.as_wr_vld), 0);
        check("abort_done", 32'(bus.addr_seq_done), 0);
        @(posedge clk);
        #1 rstn = 1'b0;
        rd_q.delete();
        wr_q.delete();
        done_exp = 0;
        for (int i = 0; i < 32; i++) begin
            rd_q.push_back(i);
            wr_q.push_back((i / 2) * 4 + 2 + (i % 2));
        end
        done_exp++;
        start_job(1'b1, 4, 4, 2, 4, 8, 0, 2);
        wait_done("after_reset", 32, 0);
        repeat (3) @(negedge clk);
        check("final_done_count", done_exp, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
